// File: rtl/rv32_types_pkg.sv
// Shared RV32 types for the writeback path: register ids, data words,
// writeback source select and load-type encodings.
package rv32_types;

    typedef logic [4:0]  rv_reg_id_t;
    typedef logic [31:0] rv32_word;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2,
        WB_PC4  = 2'd3
    } rv_wb_sel_t;

    // Encodings follow the load funct3 field
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } rv_load_t;

    function automatic logic wb_writes(input rv_wb_sel_t sel, input rv_reg_id_t rd);
        return (sel != WB_NONE) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Combinational load formatter: picks the addressed byte/half of an aligned
// memory word and sign- or zero-extends it to 32 bits.
module rv32_load_align
    import rv32_types::*;
(
    input  rv32_word   load_data,
    input  rv_load_t   load_type,
    input  logic [1:0] addr_lo,
    output rv32_word   result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = load_data[7:0];
        case (addr_lo)
            2'd0: byte_sel = load_data[7:0];
            2'd1: byte_sel = load_data[15:8];
            2'd2: byte_sel = load_data[23:16];
            2'd3: byte_sel = load_data[31:24];
            default: byte_sel = load_data[7:0];
        endcase
        // Half selection ignores addr_lo[0]; misaligned halves are not split
        half_sel = addr_lo[1] ? load_data[31:16] : load_data[15:0];
    end

    always_comb begin
        result = load_data;
        case (load_type)
            LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {24'd0, byte_sel};
            LD_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result = {16'd0, half_sel};
            LD_LW:   result = load_data;
            default: result = load_data;
        endcase
    end

endmodule

// File: rtl/rv32_writeback_stage.sv
// RV32 writeback stage: a small in-order result queue that drains into the
// register-file write port, exposes every queued entry for bypassing and
// counts retired instructions.
module rv32_writeback_stage
    import rv32_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  rv_reg_id_t             in_rd,
    input  rv_wb_sel_t             in_wb_sel,
    input  rv32_word               in_alu_result,
    input  rv32_word               in_pc,
    input  rv32_word               in_load_data,
    input  rv_load_t               in_load_type,
    input  logic [1:0]             in_addr_lo,
    input  logic                   rf_grant,
    output logic                   rf_write,
    output rv_reg_id_t             rf_rw,
    output rv32_word               rf_d,
    output logic [DEPTH-1:0]       fwd_valid,
    output logic [DEPTH-1:0][4:0]  fwd_rd,
    output logic [DEPTH-1:0][31:0] fwd_data,
    output logic [63:0]            instret
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    rv_reg_id_t rd_q   [DEPTH];
    rv32_word   data_q [DEPTH];
    logic [DEPTH-1:0] writes_q;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [63:0]      instret_q;

    logic     head_valid;
    logic     head_writes;
    logic     push;
    logic     pop;
    rv32_word load_value;
    rv32_word wb_data;

    rv32_load_align u_load_align (
        .load_data (in_load_data),
        .load_type (in_load_type),
        .addr_lo   (in_addr_lo),
        .result    (load_value)
    );

    // in_ready depends only on registered occupancy, so a full queue refuses
    // a push even in a cycle where the head is draining.
    assign in_ready    = (count < CNT_W'(DEPTH));
    assign head_valid  = (count != '0);
    assign head_writes = writes_q[rd_ptr];
    assign push        = in_valid && in_ready;
    assign pop         = head_valid && (!head_writes || rf_grant);

    always_comb begin
        wb_data = in_alu_result;
        case (in_wb_sel)
            WB_ALU:  wb_data = in_alu_result;
            WB_PC4:  wb_data = in_pc + 32'd4;
            WB_LOAD: wb_data = load_value;
            default: wb_data = in_alu_result;
        endcase
    end

    assign rf_write = head_valid && head_writes && rf_grant && !reset;
    assign rf_rw    = rf_write ? rd_q[rd_ptr]   : '0;
    assign rf_d     = rf_write ? data_q[rd_ptr] : '0;
    assign instret  = instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            instret_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (pop) instret_q <= instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            rd_q[wr_ptr]     <= in_rd;
            data_q[wr_ptr]   <= wb_data;
            writes_q[wr_ptr] <= wb_writes(in_wb_sel, in_rd);
        end
    end

    // Bypass slot i is the i-th oldest entry, counted from the read pointer
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx          = rd_ptr + PTR_W'(i);
            fwd_valid[i] = (CNT_W'(i) < count) && writes_q[idx];
            fwd_rd[i]    = rd_q[idx];
            fwd_data[i]  = data_q[idx];
        end
    end

endmodule

// File: tb/tb_rv32_writeback_stage.sv
// Self-checking bench for rv32_writeback_stage: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_rv32_writeback_stage;
    import rv32_types::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    rv_reg_id_t             in_rd;
    rv_wb_sel_t             in_wb_sel;
    rv32_word               in_alu_result;
    rv32_word               in_pc;
    rv32_word               in_load_data;
    rv_load_t               in_load_type;
    logic [1:0]             in_addr_lo;
    logic                   rf_grant;
    logic                   rf_write;
    rv_reg_id_t             rf_rw;
    rv32_word               rf_d;
    logic [DEPTH-1:0]       fwd_valid;
    logic [DEPTH-1:0][4:0]  fwd_rd;
    logic [DEPTH-1:0][31:0] fwd_data;
    logic [63:0]            instret;

    rv32_writeback_stage #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc         (in_pc),
        .in_load_data  (in_load_data),
        .in_load_type  (in_load_type),
        .in_addr_lo    (in_addr_lo),
        .rf_grant      (rf_grant),
        .rf_write      (rf_write),
        .rf_rw         (rf_rw),
        .rf_d          (rf_d),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .instret       (instret)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          wr;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_instret;
    int          checks   = 0;
    int          failures = 0;
    rv_load_t    load_kinds [5] = '{LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] fmt_load(input logic [2:0] t, input logic [31:0] w,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * int'(a)));
        h = 16'(w >> (16 * int'(a[1])));
        case (t)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [4:0] rd,
                         input rv_wb_sel_t sel, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] ld, input rv_load_t lt, input logic [1:0] alo,
                         input logic g);
        @(negedge clk);
        reset         = rst;
        in_valid      = v;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc         = pc;
        in_load_data  = ld;
        in_load_type  = lt;
        in_addr_lo    = alo;
        rf_grant      = g;
        #1;
    endtask

    task automatic idle(input logic rst, input logic g);
        drive(rst, 1'b0, 5'd0, WB_NONE, 32'd0, 32'd0, 32'd0, LD_LW, 2'd0, g);
    endtask

    // Compare every output against the model, then advance the model by the
    // edge that is about to happen with the inputs currently applied.
    task automatic model_cycle();
        bit          exp_wr;
        bit          do_pop;
        bit          do_push;
        ent_t        e;
        exp_wr = !reset && (mq.size() > 0);
        if (exp_wr) exp_wr = mq[0].wr && rf_grant;
        chk("in_ready", in_ready, (mq.size() < DEPTH));
        chk("rf_write", rf_write, exp_wr);
        if (exp_wr) begin
            chk("rf_rw", rf_rw, mq[0].rd);
            chk("rf_d", rf_d, mq[0].data);
        end else begin
            chk("rf_rw_idle", rf_rw, 0);
            chk("rf_d_idle", rf_d, 0);
        end
        chk("instret", instret, m_instret);
        for (int i = 0; i < DEPTH; i++) begin
            bit expv;
            expv = (i < mq.size());
            if (expv) expv = mq[i].wr;
            chk("fwd_valid", fwd_valid[i], expv);
            if (expv) begin
                chk("fwd_rd", fwd_rd[i], mq[i].rd);
                chk("fwd_data", fwd_data[i], mq[i].data);
            end
        end

        if (reset) begin
            mq.delete();
            m_instret = 64'd0;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0);
            if (do_pop) do_pop = !mq[0].wr || rf_grant;
            if (do_pop) begin
                void'(mq.pop_front());
                m_instret = m_instret + 64'd1;
            end
            if (do_push) begin
                e.rd = in_rd;
                e.wr = (in_wb_sel != WB_NONE) && (in_rd != 5'd0);
                case (in_wb_sel)
                    WB_ALU:  e.data = in_alu_result;
                    WB_PC4:  e.data = in_pc + 32'd4;
                    WB_LOAD: e.data = fmt_load(in_load_type, in_load_data, in_addr_lo);
                    default: e.data = 32'd0;
                endcase
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        m_instret = 64'd0;
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        model_cycle();

        // Byte/half load formatting and PC+4 wrap
        drive(0, 1, 5'd7, WB_LOAD, 32'd0, 32'd0, 32'h80FF7F01, LD_LB, 2'd3, 1);
        model_cycle();
        drive(0, 1, 5'd8, WB_LOAD, 32'd0, 32'd0, 32'h80FF7F01, LD_LBU, 2'd3, 1);
        chk("lb_write", rf_write, 1);
        chk("lb_rw", rf_rw, 7);
        chk("lb_data", rf_d, 32'hFFFFFF80);
        model_cycle();
        drive(0, 1, 5'd9, WB_LOAD, 32'd0, 32'd0, 32'h80011234, LD_LH, 2'd3, 1);
        chk("lbu_data", rf_d, 32'h00000080);
        model_cycle();
        drive(0, 1, 5'd10, WB_LOAD, 32'd0, 32'd0, 32'h80011234, LD_LHU, 2'd0, 1);
        chk("lh_data", rf_d, 32'hFFFF8001);
        model_cycle();
        drive(0, 1, 5'd5, WB_PC4, 32'd0, 32'hFFFFFFFC, 32'd0, LD_LW, 2'd0, 1);
        chk("lhu_data", rf_d, 32'h00001234);
        model_cycle();
        drive(0, 1, 5'd0, WB_ALU, 32'hDEADBEEF, 32'd0, 32'd0, LD_LW, 2'd0, 1);
        chk("pc4_write", rf_write, 1);
        chk("pc4_rw", rf_rw, 5);
        chk("pc4_data", rf_d, 32'h0);
        model_cycle();
        idle(0, 1);
        chk("x0_no_write", rf_write, 0);
        chk("instret_5", instret, 64'd5);
        model_cycle();
        idle(0, 0);
        chk("x0_retired", instret, 64'd6);
        model_cycle();

        // Backpressure: two entries held without grant, then drained in order
        drive(0, 1, 5'd1, WB_ALU, 32'h11111111, 32'd0, 32'd0, LD_LW, 2'd0, 0);
        model_cycle();
        drive(0, 1, 5'd2, WB_ALU, 32'h22222222, 32'd0, 32'd0, LD_LW, 2'd0, 0);
        model_cycle();
        idle(0, 0);
        chk("full_ready", in_ready, 0);
        chk("full_fwd", fwd_valid, 2'b11);
        chk("held_write", rf_write, 0);
        model_cycle();
        idle(0, 1);
        chk("drain1_write", rf_write, 1);
        chk("drain1_rw", rf_rw, 1);
        model_cycle();
        idle(0, 1);
        chk("drain2_write", rf_write, 1);
        chk("drain2_rw", rf_rw, 2);
        chk("drain2_ready", in_ready, 1);
        model_cycle();

        // Reset with two queued entries
        drive(0, 1, 5'd3, WB_ALU, 32'h33333333, 32'd0, 32'd0, LD_LW, 2'd0, 0);
        model_cycle();
        drive(0, 1, 5'd4, WB_ALU, 32'h44444444, 32'd0, 32'd0, LD_LW, 2'd0, 0);
        model_cycle();
        idle(1, 1);
        chk("rst_no_write", rf_write, 0);
        model_cycle();
        idle(0, 1);
        chk("post_rst_write", rf_write, 0);
        chk("post_rst_instret", instret, 64'd0);
        chk("post_rst_fwd", fwd_valid, 2'b00);
        chk("post_rst_ready", in_ready, 1);
        model_cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rd,
                  rv_wb_sel_t'(2'($urandom_range(0, 3))), $urandom, $urandom, $urandom,
                  load_kinds[$urandom_range(0, 4)], 2'($urandom),
                  ($urandom_range(0, 9) < 7));
            model_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
